// File: rtl/branch_resolve_stage.sv
// Branch resolve stage: rebuilds the B-type offset from the split instruction
// fields, evaluates the branch condition, and hands one registered result per
// branch downstream through a two-entry (main + skid) output buffer.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and payload stable until that edge. in_ready
// is a register output; it is high whenever the skid entry is empty. out_valid
// and the payload outputs come straight from the main register. They hold
// steady while out_valid && !out_ready.
module branch_resolve_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       imm_b_msb,
    input  logic [4:0]       imm_b_lsb,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  next_pc,
    output logic             misaligned,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] next_pc;
        logic            misaligned;
        logic            illegal;
    } res_t;

    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc4;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_cond;
    logic            w_illegal;
    res_t            w_new;
    logic            w_in_hs;
    logic            w_out_hs;

    res_t            r_main;
    res_t            r_skid;
    logic            r_main_valid;
    logic            r_skid_valid;
    logic            r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    // Offset bit order is {imm[12], imm[11], imm[10:5], imm[4:1], 0}, sign-extended.
    assign w_imm    = {{(XLEN-13){imm_b_msb[6]}}, imm_b_msb[6], imm_b_lsb[0],
                       imm_b_msb[5:0], imm_b_lsb[4:1], 1'b0};
    assign w_target = pc + w_imm;
    assign w_pc4    = pc + {{(XLEN-3){1'b0}}, 3'd4};

    assign w_eq  = (rs1_data == rs2_data);
    assign w_lt  = ($signed(rs1_data) < $signed(rs2_data));
    assign w_ltu = (rs1_data < rs2_data);

    // Branch condition select; the two reserved encodings never take.
    always_comb begin
        w_cond    = 1'b0;
        w_illegal = 1'b0;
        case (funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = !w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = !w_ltu;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_new.taken      = w_cond;
    assign w_new.target     = w_target;
    assign w_new.next_pc    = w_cond ? w_target : w_pc4;
    assign w_new.misaligned = w_cond && w_target[1];
    assign w_new.illegal    = w_illegal;

    assign w_in_hs  = in_valid && r_in_ready;
    assign w_out_hs = r_main_valid && out_ready;

    // Main/skid buffer update, taken counter, and registered in_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_cnt        <= '0;
        end else begin
            if (w_out_hs && r_main.taken) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (!r_main_valid) begin
                // Skid is always empty when main is empty.
                if (w_in_hs) begin
                    r_main       <= w_new;
                    r_main_valid <= 1'b1;
                end
            end else if (w_out_hs) begin
                if (r_skid_valid) begin
                    // in_ready was low, so no new input can arrive this edge.
                    r_main       <= r_skid;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end else if (w_in_hs) begin
                    r_main <= w_new;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_in_hs) begin
                r_skid       <= w_new;
                r_skid_valid <= 1'b1;
                r_in_ready   <= 1'b0;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_main_valid;
    assign taken      = r_main.taken;
    assign target     = r_main.target;
    assign next_pc    = r_main.next_pc;
    assign misaligned = r_main.misaligned;
    assign illegal    = r_main.illegal;
    assign taken_cnt  = r_cnt;

endmodule
